// File: rtl/arb_mux_n.sv
// arb_mux_n: one FIFO per input channel, merged onto a single registered output
// by a round-robin (MODE 0) or fixed-priority (MODE 1, lowest index wins) arbiter.
module arb_mux_n #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 64,
  parameter int DEPTH  = 8,
  parameter int MODE   = 0
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic [NUM_CH-1:0]         i_DataValid,
  input  logic [NUM_CH*WIDTH-1:0]   i_DataIn,
  output logic [NUM_CH-1:0]         o_DataGrant,
  input  logic                      i_DataGrant,
  output logic                      o_DataValid,
  output logic [WIDTH-1:0]          o_DataOut,
  output logic [$clog2(NUM_CH)-1:0] o_ChId,
  output logic [NUM_CH-1:0]         o_Overflow
);

  localparam int CHW = $clog2(NUM_CH);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int SW  = CHW + 1;

  logic [WIDTH-1:0]  mem_q    [NUM_CH][DEPTH];
  logic [PW-1:0]     wr_ptr_q [NUM_CH];
  logic [PW-1:0]     wr_ptr_d [NUM_CH];
  logic [PW-1:0]     rd_ptr_q [NUM_CH];
  logic [PW-1:0]     rd_ptr_d [NUM_CH];
  logic [CW-1:0]     count_q  [NUM_CH];
  logic [CW-1:0]     count_d  [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [CHW-1:0]    rr_ptr_q, rr_ptr_d;
  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [CHW-1:0]    ch_q, ch_d;

  logic [NUM_CH-1:0] req, push, pop;
  logic              load, any_req;
  logic [CHW-1:0]    win_idx;

  // Grant depends only on the registered count, so a pop in the same cycle
  // cannot open a slot early.
  always_comb begin
    o_DataGrant = '0;
    req         = '0;
    push        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      o_DataGrant[i] = (count_q[i] != CW'(DEPTH));
      req[i]         = (count_q[i] != '0);
      push[i]        = i_DataValid[i] && o_DataGrant[i];
    end
  end

  always_comb begin
    logic [SW-1:0] cand;
    logic          found;
    cand    = '0;
    found   = 1'b0;
    win_idx = '0;
    any_req = |req;
    for (int k = 0; k < NUM_CH; k++) begin
      if (MODE == 0) begin
        cand = {1'b0, rr_ptr_q} + SW'(k);
        if (cand >= SW'(NUM_CH)) cand = cand - SW'(NUM_CH);
      end else begin
        cand = SW'(k);
      end
      if (!found && req[cand[CHW-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[CHW-1:0];
      end
    end
  end

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path can leave a value unassigned and infer a latch.
  always_comb begin
    load     = !valid_q || i_DataGrant;
    pop      = '0;
    valid_d  = valid_q;
    data_d   = data_q;
    ch_d     = ch_q;
    rr_ptr_d = rr_ptr_q;
    ovf_d    = ovf_q | (i_DataValid & ~o_DataGrant);
    if (load) begin
      valid_d = any_req;
      if (any_req) begin
        pop[win_idx] = 1'b1;
        data_d       = mem_q[win_idx][rd_ptr_q[win_idx]];
        ch_d         = win_idx;
        if (MODE == 0) begin
          rr_ptr_d = (win_idx == CHW'(NUM_CH - 1)) ? '0 : win_idx + CHW'(1);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wr_ptr_d[i] = wr_ptr_q[i];
      rd_ptr_d[i] = rd_ptr_q[i];
      count_d[i]  = count_q[i];
      if (push[i]) wr_ptr_d[i] = wr_ptr_q[i] + PW'(1);
      if (pop[i])  rd_ptr_d[i] = rd_ptr_q[i] + PW'(1);
      case ({push[i], pop[i]})
        2'b10:   count_d[i] = count_q[i] + CW'(1);
        2'b01:   count_d[i] = count_q[i] - CW'(1);
        default: count_d[i] = count_q[i];
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      ovf_q    <= '0;
      rr_ptr_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      ch_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      ch_q     <= ch_d;
    end
  end

  // NOTE: storage is deliberately not reset; zeroed counts and pointers make
  // any stale contents unreachable, and a reset-free array maps onto RAM.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (!Reset && push[i]) mem_q[i][wr_ptr_q[i]] <= i_DataIn[i*WIDTH +: WIDTH];
    end
  end

  assign o_DataValid = valid_q;
  assign o_DataOut   = data_q;
  assign o_ChId      = ch_q;
  assign o_Overflow  = ovf_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// Directed bench for arb_mux_n: a vector table for basic flow and round-robin
// order, plus hand-written sequences for fairness, priority, overflow and reset.
module tb_arb_mux_n;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  vld;
  logic [63:0] din;
  logic        gin;

  logic [3:0]  dg_rr, ovf_rr, dg_fp, ovf_fp;
  logic        ov_rr, ov_fp;
  logic [15:0] do_rr, do_fp;
  logic [1:0]  ch_rr, ch_fp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  arb_mux_n #(.NUM_CH(4), .WIDTH(16), .DEPTH(8), .MODE(0)) dut_rr (
    .CLK(clk), .Reset(rst), .i_DataValid(vld), .i_DataIn(din),
    .o_DataGrant(dg_rr), .i_DataGrant(gin), .o_DataValid(ov_rr),
    .o_DataOut(do_rr), .o_ChId(ch_rr), .o_Overflow(ovf_rr)
  );

  arb_mux_n #(.NUM_CH(4), .WIDTH(16), .DEPTH(8), .MODE(1)) dut_fp (
    .CLK(clk), .Reset(rst), .i_DataValid(vld), .i_DataIn(din),
    .o_DataGrant(dg_fp), .i_DataGrant(gin), .o_DataValid(ov_fp),
    .o_DataOut(do_fp), .o_ChId(ch_fp), .o_Overflow(ovf_fp)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [63:0] din;
    logic        gin;
    logic        e_ov;
    logic [15:0] e_data;
    logic [1:0]  e_ch;
    logic [3:0]  e_dg;
    logic [3:0]  e_ovf;
  } vec_t;

  vec_t vecs [13];

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [63:0] d,
                              input logic g, input logic eov, input logic [15:0] edata,
                              input logic [1:0] ech, input logic [3:0] edg,
                              input logic [3:0] eovf);
    vec_t t;
    t.rst = r; t.vld = v; t.din = d; t.gin = g;
    t.e_ov = eov; t.e_data = edata; t.e_ch = ech; t.e_dg = edg; t.e_ovf = eovf;
    return t;
  endfunction

  function automatic logic [15:0] word(input int c, input int n);
    return 16'hC000 | 16'(c << 8) | 16'(n);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_rr(input string tag, input logic eov, input logic [15:0] edata,
                          input logic [1:0] ech);
    check({tag, " valid"}, 64'(ov_rr), 64'(eov));
    check({tag, " data"},  64'(do_rr), 64'(edata));
    check({tag, " chid"},  64'(ch_rr), 64'(ech));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic [15:0] v);
    din[c*16 +: 16] = v;
  endtask

  task automatic do_reset();
    rst = 1'b1; vld = '0; gin = 1'b0; din = '0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; vld = '0; din = '0; gin = 1'b0;

    // Reset, single word on ch2, then round-robin pointer behaviour incl. wrap.
    vecs[0]  = mk(1, 4'b0000, 64'h0,                   0, 0, 16'h0000, 2'd0, 4'hF, 4'h0);
    vecs[1]  = mk(0, 4'b0100, 64'h0000_00A5_0000_0000, 1, 0, 16'h0000, 2'd0, 4'hF, 4'h0);
    vecs[2]  = mk(0, 4'b0000, 64'h0,                   1, 1, 16'h00A5, 2'd2, 4'hF, 4'h0);
    vecs[3]  = mk(0, 4'b0000, 64'h0,                   1, 0, 16'h00A5, 2'd2, 4'hF, 4'h0);
    vecs[4]  = mk(0, 4'b0011, 64'h0000_0000_1100_1000, 0, 0, 16'h00A5, 2'd2, 4'hF, 4'h0);
    vecs[5]  = mk(0, 4'b0000, 64'h0,                   0, 1, 16'h1000, 2'd0, 4'hF, 4'h0);
    vecs[6]  = mk(0, 4'b0000, 64'h0,                   0, 1, 16'h1000, 2'd0, 4'hF, 4'h0);
    vecs[7]  = mk(0, 4'b0000, 64'h0,                   1, 1, 16'h1100, 2'd1, 4'hF, 4'h0);
    vecs[8]  = mk(0, 4'b0000, 64'h0,                   1, 0, 16'h1100, 2'd1, 4'hF, 4'h0);
    vecs[9]  = mk(0, 4'b1010, 64'h2300_0000_2100_0000, 1, 0, 16'h1100, 2'd1, 4'hF, 4'h0);
    vecs[10] = mk(0, 4'b0000, 64'h0,                   1, 1, 16'h2300, 2'd3, 4'hF, 4'h0);
    vecs[11] = mk(0, 4'b0000, 64'h0,                   1, 1, 16'h2100, 2'd1, 4'hF, 4'h0);
    vecs[12] = mk(0, 4'b0000, 64'h0,                   1, 0, 16'h2100, 2'd1, 4'hF, 4'h0);

    for (int i = 0; i < 13; i++) begin
      rst = vecs[i].rst; vld = vecs[i].vld; din = vecs[i].din; gin = vecs[i].gin;
      tick();
      check_rr($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_data, vecs[i].e_ch);
      check($sformatf("vec%0d grant", i), 64'(dg_rr), 64'(vecs[i].e_dg));
      check($sformatf("vec%0d ovf", i), 64'(ovf_rr), 64'(vecs[i].e_ovf));
    end

    // Backpressure hold, then round-robin fairness over 12 queued words.
    do_reset();
    for (int n = 0; n < 3; n++) begin
      vld = 4'hF;
      for (int c = 0; c < 4; c++) set_ch(c, word(c, n));
      tick();
    end
    vld = '0;
    for (int b = 0; b < 5; b++) begin
      tick();
      check_rr($sformatf("hold%0d", b), 1'b1, word(0, 0), 2'd0);
    end
    for (int i = 0; i < 12; i++) begin
      check_rr($sformatf("rr%0d", i), 1'b1, word(i % 4, i / 4), 2'(i % 4));
      gin = 1'b1;
      tick();
    end
    check("rr drained valid", 64'(ov_rr), 64'd0);

    // Fixed priority: ch0 and ch3 hold two words each.
    do_reset();
    vld = 4'b1001; set_ch(0, word(0, 0)); set_ch(3, word(3, 0));
    tick();
    set_ch(0, word(0, 1)); set_ch(3, word(3, 1));
    tick();
    vld = '0; gin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fp%0d valid", i), 64'(ov_fp), 64'd1);
      check($sformatf("fp%0d chid", i),  64'(ch_fp), (i < 2) ? 64'd0 : 64'd3);
      check($sformatf("fp%0d data", i),  64'(do_fp), 64'(word((i < 2) ? 0 : 3, i % 2)));
      tick();
    end
    check("fp drained valid", 64'(ov_fp), 64'd0);

    // Overflow: output register occupied by ch0, then ch1 receives 9 words.
    do_reset();
    vld = 4'b0001; set_ch(0, 16'h0BAD);
    tick();
    vld = '0;
    tick();
    check_rr("ovf pre", 1'b1, 16'h0BAD, 2'd0);
    for (int n = 0; n < 9; n++) begin
      check($sformatf("ovf grant before w%0d", n), 64'(dg_rr[1]), (n < 8) ? 64'd1 : 64'd0);
      vld = 4'b0010; set_ch(1, word(1, n));
      tick();
      check($sformatf("ovf flag after w%0d", n), 64'(ovf_rr), (n == 8) ? 64'h2 : 64'h0);
    end
    check("ovf full grant", 64'(dg_rr), 64'hD);
    vld = '0; gin = 1'b1;
    for (int n = 0; n < 8; n++) begin
      tick();
      check_rr($sformatf("ovf drain%0d", n), 1'b1, word(1, n), 2'd1);
      check($sformatf("ovf sticky%0d", n), 64'(ovf_rr), 64'h2);
    end
    check("ovf grant reopened", 64'(dg_rr), 64'hF);
    tick();
    check("ovf drained valid", 64'(ov_rr), 64'd0);

    // Reset mid-stream: 3 words queued on ch2 plus one in the output register.
    gin = 1'b0;
    for (int n = 0; n < 4; n++) begin
      vld = 4'b0100; set_ch(2, word(2, n));
      tick();
    end
    check_rr("mid pre", 1'b1, word(2, 0), 2'd2);
    rst = 1'b1; vld = 4'hF; din = 64'hFFFF_EEEE_DDDD_CCCC; gin = 1'b1;
    tick();
    rst = 1'b0; vld = '0;
    check_rr("mid reset", 1'b0, 16'h0000, 2'd0);
    check("mid reset grant", 64'(dg_rr), 64'hF);
    check("mid reset ovf", 64'(ovf_rr), 64'h0);
    for (int b = 0; b < 5; b++) begin
      tick();
      check($sformatf("mid idle%0d valid", b), 64'(ov_rr), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arb_mux_n.md
ARB_MUX_N -- requirements
Module: arb_mux_n

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of input channels (legal 2..8).
REQ-002 SHALL have parameter WIDTH, default 64, data bits per word.
REQ-003 SHALL have parameter DEPTH, default 8, words per channel FIFO (power of two, >=2).
REQ-004 SHALL have parameter MODE, default 0, arbitration: 0 round-robin, 1 fixed priority (lowest index wins).
REQ-005 SHALL have port CLK  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port Reset  input  1  synchronous reset, active-high.
REQ-007 SHALL have port i_DataValid  input  NUM_CH  per-channel write strobe.
REQ-008 SHALL have port i_DataIn  input  NUM_CH*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port o_DataGrant  output  NUM_CH  per-channel "FIFO can accept".
REQ-010 SHALL have port i_DataGrant  input  1  downstream ready.
REQ-011 SHALL have port o_DataValid  output  1  output word valid.
REQ-012 SHALL have port o_DataOut  output  WIDTH  output word.
REQ-013 SHALL have port o_ChId  output  $clog2(NUM_CH)  source channel of o_DataOut.
REQ-014 SHALL have port o_Overflow  output  NUM_CH  sticky per-channel drop flag.

Function
REQ-015 SHALL contain one DEPTH-entry FIFO per channel with count register 0..DEPTH.
REQ-016 SHALL drive o_DataGrant[i] = (count[i] != DEPTH), from registered state only; a same-cycle pop does not raise it.
REQ-017 SHALL write i_DataIn word i into FIFO i on an edge where i_DataValid[i] && o_DataGrant[i].
REQ-018 SHALL drop the word and set o_Overflow[i] on an edge where i_DataValid[i] && !o_DataGrant[i]; o_Overflow clears only by Reset.
REQ-019 SHALL have a single output register (o_DataValid, o_DataOut, o_ChId); "load" = !o_DataValid || i_DataGrant.
REQ-020 SHALL, on a load edge with at least one non-empty FIFO, pop the arbitration winner's head into the output register and set o_DataValid=1.
REQ-021 SHALL, on a load edge with all FIFOs empty, clear o_DataValid; o_DataOut/o_ChId hold last value.
REQ-022 SHALL hold o_DataValid, o_DataOut, o_ChId stable while o_DataValid && !i_DataGrant.
REQ-023 SHALL in MODE 0 search requesters starting at pointer rr_ptr, wrapping NUM_CH-1 -> 0; after a pop from channel w, rr_ptr <= (w+1) mod NUM_CH; no pop leaves rr_ptr unchanged.
REQ-024 SHALL in MODE 1 grant the lowest-index non-empty FIFO; rr_ptr unused.
REQ-025 SHALL give minimum latency 2 edges: word written at edge k appears with o_DataValid=1 after edge k+1 (no bypass path).
REQ-026 SHALL allow push and pop on the same FIFO in one edge; count unchanged, data order preserved.
REQ-027 SHALL wrap FIFO read/write pointers modulo DEPTH; FIFO order strictly preserved per channel.
REQ-028 SHALL sustain one output word per cycle while i_DataGrant=1 and any FIFO non-empty.

Reset
REQ-029 SHALL, on an edge with Reset=1, set all counts and pointers 0, rr_ptr=0, o_DataValid=0, o_DataOut=0, o_ChId=0, o_Overflow=0, regardless of in-flight words (discarded).
REQ-030 SHALL drive o_DataGrant all-ones during the first cycle after reset release.
REQ-031 SHALL ignore i_DataValid and i_DataGrant on any edge where Reset=1.

Verification
REQ-032 Single word: ch2 writes 0xA5 at edge k, i_DataGrant=1 -> o_DataValid=1, o_DataOut=0xA5, o_ChId=2 after edge k+1, o_DataValid=0 after k+2.
REQ-033 RR fairness (MODE 0, NUM_CH=4): all four FIFOs hold 3 words, i_DataGrant=1 -> o_ChId sequence 0,1,2,3,0,1,2,3,0,1,2,3, no idle cycles.
REQ-034 Fixed priority (MODE 1): ch0 and ch3 each hold 2 words -> o_ChId 0,0,3,3.
REQ-035 Full/overflow: ch1 writes 9 words with i_DataGrant=0, DEPTH=8 -> o_DataGrant[1]=0 after 8th; 9th dropped; o_Overflow[1]=1 and stays 1; after release, first 8 words emerge in order.
REQ-036 Backpressure: o_DataValid=1, i_DataGrant=0 for 5 cycles -> o_DataOut/o_ChId unchanged, no FIFO pop, rr_ptr unchanged.
REQ-037 Reset mid-stream: Reset=1 for one edge with 3 words queued and o_DataValid=1 -> next cycle o_DataValid=0, o_DataGrant=all-ones, o_Overflow=0, no stale word ever output.
